// File: rtl/shift_fu_pkg.sv
// Shared definitions for the shift functional unit: default widths, opcodes,
// the result record and the opcode-to-shifter-control decode.
package shift_fu_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_SHW        = 5;
    localparam int DEF_TAGW       = 4;
    localparam int DEF_OBUF_DEPTH = 4;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLA = 2'b10;
    localparam logic [1:0] OP_SLL = 2'b11;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_TAGW-1:0]  tag;
    } result_t;

    typedef struct packed {
        logic left;
        logic log;
    } shctl_t;

    // Left shifts are always logical; only right shifts distinguish SRA/SRL.
    function automatic shctl_t decode_op(input logic [1:0] op);
        shctl_t c;
        c = '0;
        unique case (op)
            OP_SRA: begin c.left = 1'b0; c.log = 1'b0; end
            OP_SRL: begin c.left = 1'b0; c.log = 1'b1; end
            OP_SLA: begin c.left = 1'b1; c.log = 1'b0; end
            OP_SLL: begin c.left = 1'b1; c.log = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shift_result_fifo.sv
// In-order result buffer between the shifter output and the consumer.
// Pointers wrap modulo DEPTH so non-power-of-two depths work.
module shift_result_fifo #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic [TAGW-1:0]  push_tag_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic [TAGW-1:0]  head_tag_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH+TAGW-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= {push_data_i, push_tag_i};
    end

    assign valid_o     = (count_q != '0);
    assign head_data_o = mem_q[rd_ptr_q][WIDTH+TAGW-1:TAGW];
    assign head_tag_o  = mem_q[rd_ptr_q][TAGW-1:0];
    assign count_o     = count_q;

endmodule

// File: rtl/shift_issue_ctrl.sv
// Issue/retire controller around a 1-cycle barrel shifter: issue register,
// one tracking stage for the shifter latency, credit-gated result FIFO.
module shift_issue_ctrl
    import shift_fu_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SHW        = DEF_SHW,
    parameter int TAGW       = DEF_TAGW,
    parameter int OBUF_DEPTH = DEF_OBUF_DEPTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [SHW-1:0]   in_amt,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAGW-1:0]  in_tag,
    input  logic             in_flush,
    output logic [WIDTH-1:0] sh_x,
    output logic [SHW-1:0]   sh_s,
    output logic             sh_left,
    output logic             sh_log,
    input  logic [WIDTH-1:0] sh_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             idle
);

    localparam int CW = $clog2(OBUF_DEPTH + 1);

    logic [WIDTH-1:0] sh_x_q, sh_x_d;
    logic [SHW-1:0]   sh_s_q, sh_s_d;
    logic             sh_left_q, sh_left_d;
    logic             sh_log_q, sh_log_d;
    logic [TAGW-1:0]  tag1_q, tag1_d;
    logic [TAGW-1:0]  tag2_q, tag2_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;

    logic [CW-1:0]    fifo_count;
    logic [CW:0]      occupancy;
    logic             accept;
    logic             fifo_push;
    logic             fifo_pop;
    shctl_t           ctl;

    // Every op that could still land in the FIFO holds a credit, so the
    // non-stallable shifter output always has a free slot when it arrives.
    always_comb begin
        occupancy = (CW+1)'(v1_q) + (CW+1)'(v2_q) + (CW+1)'(fifo_count);
        in_ready  = (occupancy < (CW+1)'(OBUF_DEPTH)) && !in_flush;
        accept    = in_valid && in_ready;
        ctl       = decode_op(in_op);
    end

    always_comb begin
        sh_x_d    = sh_x_q;
        sh_s_d    = sh_s_q;
        sh_left_d = sh_left_q;
        sh_log_d  = sh_log_q;
        tag1_d    = tag1_q;
        v1_d      = accept;
        v2_d      = v1_q;
        tag2_d    = tag1_q;
        if (accept) begin
            sh_x_d    = in_data;
            sh_s_d    = in_amt;
            sh_left_d = ctl.left;
            sh_log_d  = ctl.log;
            tag1_d    = in_tag;
        end
        if (in_flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh_x_q    <= '0;
            sh_s_q    <= '0;
            sh_left_q <= 1'b0;
            sh_log_q  <= 1'b0;
            tag1_q    <= '0;
            tag2_q    <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
        end else begin
            sh_x_q    <= sh_x_d;
            sh_s_q    <= sh_s_d;
            sh_left_q <= sh_left_d;
            sh_log_q  <= sh_log_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
        end
    end

    // v2 marks the cycle in which sh_z carries the op issued two edges ago.
    assign fifo_push = v2_q && !in_flush;
    assign fifo_pop  = out_valid && out_ready;

    shift_result_fifo #(
        .WIDTH (WIDTH),
        .TAGW  (TAGW),
        .DEPTH (OBUF_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .resetn      (resetn),
        .flush_i     (in_flush),
        .push_i      (fifo_push),
        .push_data_i (sh_z),
        .push_tag_i  (tag2_q),
        .pop_i       (fifo_pop),
        .valid_o     (out_valid),
        .head_data_o (out_data),
        .head_tag_o  (out_tag),
        .count_o     (fifo_count)
    );

    assign sh_x    = sh_x_q;
    assign sh_s    = sh_s_q;
    assign sh_left = sh_left_q;
    assign sh_log  = sh_log_q;
    assign idle    = !v1_q && !v2_q && (fifo_count == '0);

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Directed bench for shift_issue_ctrl with a behavioural 1-cycle shifter beside it.
module tb_shift_issue_ctrl;
    import shift_fu_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int SW = DEF_SHW;
    localparam int TW = DEF_TAGW;
    localparam int RW = $bits(result_t);

    logic          clock;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [SW-1:0] in_amt;
    logic [W-1:0]  in_data;
    logic [TW-1:0] in_tag;
    logic          in_flush;
    logic [W-1:0]  sh_x;
    logic [SW-1:0] sh_s;
    logic          sh_left;
    logic          sh_log;
    logic [W-1:0]  sh_z;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          idle;

    int vec_cnt = 0;
    int miscmp  = 0;
    int cyc     = 0;
    int pop_cnt = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc  = 0;
    logic [RW-1:0] exp_q[$];

    typedef struct {
        logic [1:0]    op;
        logic [SW-1:0] amt;
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp;
    } vec_t;
    vec_t tbl[9];

    shift_issue_ctrl dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_flush  (in_flush),
        .sh_x      (sh_x),
        .sh_s      (sh_s),
        .sh_left   (sh_left),
        .sh_log    (sh_log),
        .sh_z      (sh_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .idle      (idle)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [SW-1:0] a,
                                               input logic [1:0] op);
        logic signed [W-1:0] s;
        s = d;
        case (op)
            2'b00:   return s >>> a;
            2'b01:   return d >> a;
            default: return d << a;
        endcase
    endfunction

    // Behavioural shifter: samples sh_* at an edge, Z valid the following cycle.
    always @(posedge clock) sh_z <= ref_shift(sh_x, sh_s, {sh_left, sh_log});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        if (!resetn || in_flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    miscmp++;
                    $display("FAIL sb_unexpected: got %0h expected no result", {out_data, out_tag});
                end else begin
                    check("sb_result", 64'({out_data, out_tag}), 64'(exp_q.pop_front()));
                end
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_cnt++;
            end
            if (in_valid && in_ready)
                exp_q.push_back({ref_shift(in_data, in_amt, in_op), in_tag});
            if (dut.fifo_push && (int'(dut.fifo_count) == DEF_OBUF_DEPTH) && !(out_valid && out_ready)) begin
                vec_cnt++;
                miscmp++;
                $display("FAIL fifo_overflow: got push into full FIFO, required none");
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic drive_op(input logic [1:0] op, input logic [SW-1:0] amt, input logic [W-1:0] data,
                            input logic [TW-1:0] tag, output int stall, output bit ok);
        in_valid = 1'b1;
        in_op    = op;
        in_amt   = amt;
        in_data  = data;
        in_tag   = tag;
        stall    = 0;
        ok       = 1'b0;
        while (stall < 40) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock); #1;
                ok = 1'b1;
                break;
            end
            stall++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int stall;
        bit ok;
        int lat;
        int n;

        tbl[0] = '{OP_SRA, 5'd4,  32'h8000_00F0, 4'd3, 32'hF800_000F};
        tbl[1] = '{OP_SLL, 5'd31, 32'h0000_0001, 4'd1, 32'h8000_0000};
        tbl[2] = '{OP_SRL, 5'd31, 32'h8000_0000, 4'd2, 32'h0000_0001};
        tbl[3] = '{OP_SRA, 5'd31, 32'h8000_0000, 4'd4, 32'hFFFF_FFFF};
        tbl[4] = '{OP_SLA, 5'd1,  32'h0000_0003, 4'd5, 32'h0000_0006};
        tbl[5] = '{OP_SRA, 5'd0,  32'hDEAD_BEEF, 4'd6, 32'hDEAD_BEEF};
        tbl[6] = '{OP_SRL, 5'd0,  32'hDEAD_BEEF, 4'd7, 32'hDEAD_BEEF};
        tbl[7] = '{OP_SLA, 5'd0,  32'hDEAD_BEEF, 4'd8, 32'hDEAD_BEEF};
        tbl[8] = '{OP_SLL, 5'd0,  32'hDEAD_BEEF, 4'd9, 32'hDEAD_BEEF};

        resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_amt = '0; in_data = '0;
        in_tag = '0; in_flush = 1'b0; out_ready = 1'b0;

        // Reset state, sampled between edges.
        repeat (2) @(posedge clock);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_sh_x", 64'(sh_x), 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        step(1);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single ops from the table: decode, latency, result, return to idle.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_op(tbl[i].op, tbl[i].amt, tbl[i].data, tbl[i].tag, stall, ok);
            check("tbl_accept", 64'(ok), 64'd1);
            check("tbl_sh_x", 64'(sh_x), 64'(tbl[i].data));
            check("tbl_sh_ctl", 64'({sh_s, sh_left, sh_log}), 64'({tbl[i].amt, tbl[i].op}));
            wait_out_valid(lat);
            check("tbl_latency", 64'(lat), 64'd2);
            check("tbl_data", 64'(out_data), 64'(tbl[i].exp));
            check("tbl_tag", 64'(out_tag), 64'(tbl[i].tag));
            step(1);
            check("tbl_idle", 64'({idle, out_valid}), 64'b10);
        end

        // Back-to-back stream with a free consumer.
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, 4'(i), stall, ok);
            check("stream_no_stall", 64'(stall), 64'd0);
        end
        n = 0;
        while (pop_cnt < 8 && n < 20) begin step(1); n++; end
        check("stream_pops", 64'(pop_cnt), 64'd8);
        check("stream_one_per_cycle", 64'(last_pop_cyc - first_pop_cyc), 64'd7);
        check("stream_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: four credits, then in_ready must stay low.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(OP_SLL, 5'(i + 1), 32'h0000_0101 * (i + 1), 4'(i + 8), stall, ok);
            check("bp_fill_no_stall", 64'(stall), 64'd0);
        end
        in_valid = 1'b1; in_op = OP_SRL; in_amt = 5'd4; in_data = 32'hABCD_0000; in_tag = 4'd12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_ready_low", 64'(in_ready), 64'd0);
            if (exp_q.size() > 0)
                check("bp_head_stable", 64'({out_valid, out_data, out_tag}), 64'({1'b1, exp_q[0]}));
            else
                check("bp_sb_nonempty", 64'(exp_q.size()), 64'd4);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        pop_cnt = 0;
        drive_op(OP_SRL, 5'd4, 32'hABCD_0000, 4'd12, stall, ok);
        check("bp_ready_reassert", 64'(ok), 64'd1);
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 20) begin step(1); n++; end
        check("bp_pops", 64'(pop_cnt), 64'd5);
        check("bp_idle", 64'({idle, in_ready}), 64'b11);

        // Flush with one op in each of issue reg, shifter stage and FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(OP_SRA, 5'd2, 32'hF000_0000 + i, 4'(i + 1), stall, ok);
            check("fl_fill_no_stall", 64'(stall), 64'd0);
        end
        check("fl_busy", 64'({idle, out_valid}), 64'b01);
        in_flush = 1'b1;
        step(1);
        in_flush = 1'b0;
        check("fl_after", 64'({idle, out_valid}), 64'b10);
        step(3);
        check("fl_no_late_result", 64'({idle, out_valid}), 64'b10);
        out_ready = 1'b1;
        pop_cnt = 0;
        drive_op(OP_SLL, 5'd8, 32'h0000_0001, 4'd7, stall, ok);
        wait_out_valid(lat);
        check("fl_post_data", 64'(out_data), 64'h100);
        check("fl_post_tag", 64'(out_tag), 64'd7);
        step(4);
        check("fl_post_pops", 64'(pop_cnt), 64'd1);
        check("fl_post_idle", 64'(idle), 64'd1);

        // Asynchronous reset mid-flight clears everything immediately.
        out_ready = 1'b0;
        drive_op(OP_SLL, 5'd4, 32'h1234_5678, 4'd2, stall, ok);
        drive_op(OP_SRL, 5'd4, 32'h0F0F_0000, 4'd3, stall, ok);
        #3;
        resetn = 1'b0;
        #1;
        check("ar_sh", 64'({sh_x, sh_s, sh_left, sh_log}), 64'd0);
        check("ar_flags", 64'({idle, out_valid}), 64'b10);
        @(posedge clock); #1;
        resetn = 1'b1;
        step(3);
        check("ar_release", 64'({in_ready, idle, out_valid}), 64'b110);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
